// File: rtl/bira_pkg.sv
// rtl/bira_pkg.sv - shared types and constants for the BIRA fault path
package bira_pkg;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 10;
    localparam int BNK_W  = 2;
    localparam int FLAG_W = 8;
    localparam int PCAM   = 8;
    localparam int NPCAM  = 30;
    localparam int CNT_W  = 6;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [BNK_W-1:0]  bank;
        logic [FLAG_W-1:0] col_flag;
    } fault_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_TERM,
        ST_DONE
    } fq_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bira_fault_fifo.sv
// rtl/bira_fault_fifo.sv - synchronous fault_t FIFO with flush
module bira_fault_fifo
    import bira_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  fault_t wdata,
    input  logic   pop,
    output fault_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the low bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fault_t      mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bira_fault_queue.sv
// rtl/bira_fault_queue.sv - BIST-to-CAM fault queue with overflow detect (optional BIRA_FQ_DEDUP_EN)
module bira_fault_queue #(
    parameter int DEPTH      = 8,
    parameter int PCAM       = bira_pkg::PCAM,
    parameter int NPCAM      = bira_pkg::NPCAM,
    parameter int MAX_FAULTS = PCAM + NPCAM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        test_start,
    input  logic                        bist_valid,
    output logic                        bist_ready,
    input  logic [bira_pkg::ROW_W-1:0]  bist_row,
    input  logic [bira_pkg::COL_W-1:0]  bist_col,
    input  logic [bira_pkg::BNK_W-1:0]  bist_bank,
    input  logic [bira_pkg::FLAG_W-1:0] bist_col_flag,
    input  logic                        bist_done,
    output logic                        flt_valid,
    input  logic                        flt_ready,
    output logic [bira_pkg::ROW_W-1:0]  row_addr,
    output logic [bira_pkg::COL_W-1:0]  col_addr,
    output logic [bira_pkg::BNK_W-1:0]  bank_addr,
    output logic [bira_pkg::FLAG_W-1:0] col_flag,
    output logic                        early_term,
    output logic                        analysis_start,
    output logic [bira_pkg::CNT_W-1:0]  fault_cnt
);

    import bira_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FAULTS);

    fq_state_t state;
    fault_t    wdata;
    fault_t    head;
    logic      full;
    logic      empty;
    logic      accept;
    logic      unique_flt;
    logic      overflow;
    logic      push;
    logic      pop;
    logic      flush;

    assign bist_ready = (state == ST_COLLECT) && !full;
    assign flt_valid  = ((state == ST_COLLECT) || (state == ST_DRAIN)) && !empty;
    assign accept     = bist_valid && bist_ready;

`ifdef BIRA_FQ_DEDUP_EN
    logic             last_vld;
    logic [ROW_W-1:0] last_row;
    logic [COL_W-1:0] last_col;
    logic [BNK_W-1:0] last_bank;

    assign unique_flt = !(last_vld && (last_row == bist_row) &&
                          (last_col == bist_col) && (last_bank == bist_bank));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld  <= 1'b0;
            last_row  <= '0;
            last_col  <= '0;
            last_bank <= '0;
        end else if (test_start) begin
            last_vld  <= 1'b0;
            last_row  <= '0;
            last_col  <= '0;
            last_bank <= '0;
        end else if (accept) begin
            last_vld  <= 1'b1;
            last_row  <= bist_row;
            last_col  <= bist_col;
            last_bank <= bist_bank;
        end
    end
`else
    assign unique_flt = 1'b1;
`endif

    // The fault that would exceed the CAM is dropped and the queue is flushed.
    assign overflow = accept && unique_flt && (fault_cnt == MAX_CNT);
    assign push     = accept && unique_flt && !overflow && !test_start;
    assign pop      = flt_valid && flt_ready && !test_start;
    assign flush    = test_start || overflow;

    assign wdata = '{row: bist_row, col: bist_col, bank: bist_bank, col_flag: bist_col_flag};

    bira_fault_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Head contents are undefined while empty, so gate them to zero.
    assign row_addr  = flt_valid ? head.row      : '0;
    assign col_addr  = flt_valid ? head.col      : '0;
    assign bank_addr = flt_valid ? head.bank     : '0;
    assign col_flag  = flt_valid ? head.col_flag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            fault_cnt      <= '0;
            early_term     <= 1'b0;
            analysis_start <= 1'b0;
        end else begin
            early_term     <= 1'b0;
            analysis_start <= 1'b0;
            if (test_start) begin
                state     <= ST_COLLECT;
                fault_cnt <= '0;
            end else begin
                case (state)
                    ST_COLLECT: begin
                        if (overflow) begin
                            state      <= ST_TERM;
                            early_term <= 1'b1;
                            fault_cnt  <= sat_inc(fault_cnt);
                        end else begin
                            if (push)
                                fault_cnt <= sat_inc(fault_cnt);
                            if (bist_done)
                                state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (empty) begin
                            state          <= ST_DONE;
                            analysis_start <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/bira_fault_queue.md
# bira_fault_queue

Buffers the fault reports streamed by the memory BIST and hands them, one per cycle, to the pivot/non-pivot fault CAM in the redundancy-analysis path. The block also:
- counts unique faults;
- asserts `early_term` once the total exceeds the CAM capacity (`PCAM` + `NPCAM`);
- issues a one-cycle `analysis_start` pulse after BIST finishes and the queue has drained.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `PCAM`, 8: pivot CAM entries.
- `NPCAM`, 30: non-pivot CAM entries.
- `MAX_FAULTS`, `PCAM` + `NPCAM`: largest unique-fault count that is still repairable.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `test_start`  in  1  one-cycle pulse; starts or restarts a collection.
- `bist_valid`  in  1  BIST fault report valid.
- `bist_ready`  out  1  queue accepts a report.
- `bist_row`  in  10  faulty row address.
- `bist_col`  in  10  faulty column address.
- `bist_bank`  in  2  faulty bank.
- `bist_col_flag`  in  8  I/O flag, forwarded unchanged.
- `bist_done`  in  1  BIST has issued its last report.
- `flt_valid`  out  1  CAM-side fault valid.
- `flt_ready`  in  1  CAM side consumes the fault.
- `row_addr`  out  10  head-entry row.
- `col_addr`  out  10  head-entry column.
- `bank_addr`  out  2  head-entry bank.
- `col_flag`  out  8  head-entry flag.
- `early_term`  out  1  one-cycle pulse; fault count exceeded `MAX_FAULTS`.
- `analysis_start`  out  1  one-cycle pulse; all faults delivered.
- `fault_cnt`  out  6  unique faults accepted; saturates at 63.

## Operation
States: IDLE, COLLECT, DRAIN, TERM, DONE. Reset enters IDLE.

`test_start`:
- Takes effect in any state; its priority is below reset only.
- Clears the FIFO, `fault_cnt` and the dedup register, then enters COLLECT on the next cycle.

`bist_ready`:
- Equals COLLECT && !full.
- No same-cycle pass-through: a push when full is refused even if a pop occurs in the same cycle.
- Accept is `bist_valid` && `bist_ready`. An accepted unique fault increments `fault_cnt`.

Early termination:
- An accept that would make `fault_cnt` = `MAX_FAULTS`+1 is discarded. That same cycle the FIFO is flushed, `early_term` is registered for the next cycle, and the state moves to TERM.
- `fault_cnt` holds `MAX_FAULTS`+1.

State transitions:
- COLLECT → DRAIN when `bist_done` = 1. A fault accepted in the same cycle as `bist_done` is kept.
- DRAIN → DONE when the FIFO is empty; `analysis_start` pulses on DONE entry.
- TERM and DONE hold until `test_start`.

CAM-side output:
- `flt_valid` = !empty, in the COLLECT and DRAIN states only.
- The outputs show the head entry. A pop occurs on `flt_valid` && `flt_ready`.
- Outputs hold stable while `flt_valid` && !`flt_ready`.

FIFO pointers:
- `$clog2(DEPTH)`+1 bits wide; they wrap modulo `2*DEPTH`.
- Full when the MSBs differ and the low bits are equal.

`fault_cnt` saturates at 63 and never wraps.

## Timing
Reset values (asynchronous, on `rst_n` low):
- All outputs are 0: `bist_ready`, `flt_valid`, `early_term`, `analysis_start`, `fault_cnt`, and the address and flag outputs.
- Pointers are 0 and the state is IDLE.
- Reset mid-collection discards all queued faults.

Latencies:
- Accept at edge N → `flt_valid` at N+1 if the FIFO was empty.
- `early_term` is high exactly one cycle, starting the cycle after the overflowing accept.
- `analysis_start` is high one cycle, starting the cycle after the FIFO becomes empty in DRAIN.
- `test_start` at edge N → `bist_ready` = 1 from N+1.
- `early_term` and `analysis_start` are never asserted in the same cycle.

## Configuration
- `BIRA_FQ_DEDUP_EN` defined: an incoming report whose (row, col, bank) equals the last accepted report is acknowledged (`bist_ready` unchanged) but not written and not counted. The comparison register is cleared on reset and on `test_start`.
- Undefined: every accepted report is written and counted.

## Structure
- Shared package `bira_pkg` holds:
  - constants `ROW_W`=10, `COL_W`=10, `BNK_W`=2, `FLAG_W`=8, `PCAM`=8, `NPCAM`=30;
  - struct `fault_t` {row, col, bank, col_flag};
  - enum `fq_state_t`.
- One sub-module, `bira_fault_fifo`: a synchronous FIFO of `fault_t` with push/pop, full/empty and a flush input.
- The FSM, counter and dedup logic live in the top level.

## Test plan
- **Basic delivery:** `test_start`; three reports (row 5/col 9/bank 1, row 7/col 2/bank 0, row 300/col 1023/bank 3) with `flt_ready`=1, then `bist_done` → `flt_valid` one cycle after each accept, in order; `fault_cnt`=3; `analysis_start` pulses once after the third pop.
- **Backpressure:** `flt_ready`=0, push 9 reports with `DEPTH`=8 → `bist_ready` drops after 8 accepts. Outputs hold entry 0. Raising `flt_ready` delivers all 8 in order, and the 9th is accepted once space frees.
- **Overflow:** 39 distinct faults, `flt_ready`=1 → the 39th accept is discarded; `early_term` is high one cycle; state TERM; `fault_cnt`=39; `flt_valid`=0 thereafter.
- **Dedup:** with `BIRA_FQ_DEDUP_EN` defined, the same fault (row 12, col 4, bank 2) sent twice → one FIFO entry, `fault_cnt`=1. Without the macro → two entries, `fault_cnt`=2.
- **Reset mid-operation:** 4 faults queued, `rst_n` low for one cycle → all outputs 0 immediately; after `test_start`, no stale fault appears.
- **Simultaneous events:** `bist_valid` and `bist_done` in the same cycle → that fault is delivered before `analysis_start`. `test_start` during DRAIN → FIFO cleared, state COLLECT, no `analysis_start`.
